// File: rtl/fpu_arbiter_if.sv
// fpu_arbiter_if: requester-side and FPUnit-side signals of fpu_arbiter
interface fpu_arbiter_if;
   logic        req0, req1, op0, op1;
   logic [31:0] a0, b0, a1, b1;
   logic        done0, done1, err, busy;
   logic [31:0] result;
   logic [31:0] fpu_a, fpu_b, fpu_s;
   logic        fpu_multiplicando, fpu_start, fpu_finish;
   modport slave (
      input  req0, req1, op0, op1, a0, b0, a1, b1, fpu_s, fpu_finish,
      output done0, done1, result, err, busy, fpu_a, fpu_b, fpu_multiplicando, fpu_start
   );
   modport master (
      output req0, req1, op0, op1, a0, b0, a1, b1, fpu_s, fpu_finish,
      input  done0, done1, result, err, busy, fpu_a, fpu_b, fpu_multiplicando, fpu_start
   );
endinterface

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin sharing of one FPUnit between two requesters; FPU_ARB_TIMEOUT_EN adds a WAIT timeout returning qNaN with err
module fpu_arbiter #(
   parameter int TIMEOUT = 1023
) (
   input  logic         clk,
   input  logic         reset,
   fpu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t      r_state, w_next;
   logic        r_ptr, r_win, r_mul, r_err;
   logic [31:0] r_a, r_b, r_result;
   logic        w_win, w_grant, w_cap, w_abort;
`ifdef FPU_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] r_cnt;
   assign w_abort = (r_state == WAIT) && !bus.fpu_finish && (r_cnt == CW'(TIMEOUT - 1));
   // count WAIT cycles; any other state holds the counter at zero so it starts clean on entry
   always_ff @(posedge clk or posedge reset)
      if (reset) r_cnt <= '0;
      else r_cnt <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT;
   assign w_abort = 1'b0;
`endif
   assign w_grant = (r_state == IDLE) && (bus.req0 || bus.req1);
   assign w_win   = (bus.req0 && bus.req1) ? r_ptr : bus.req1;
   assign w_cap   = (r_state == WAIT) && bus.fpu_finish;
   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= IDLE;
      else r_state <= w_next;
   // next state: finish is only honoured in WAIT, so a stale level in ISSUE is ignored
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_grant ? ISSUE : IDLE;
         ISSUE:   w_next = WAIT;
         WAIT:    w_next = (w_cap || w_abort) ? RESP : WAIT;
         default: w_next = IDLE;
      endcase
   end
   // latch winner operands at grant, capture result at finish/abort, advance pointer after service
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_ptr    <= 1'b0;
         r_win    <= 1'b0;
         r_mul    <= 1'b0;
         r_err    <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
      end else begin
         if (w_grant) begin
            r_win <= w_win;
            r_a   <= w_win ? bus.a1 : bus.a0;
            r_b   <= w_win ? bus.b1 : bus.b0;
            r_mul <= w_win ? bus.op1 : bus.op0;
         end
         if (w_cap) begin
            r_result <= bus.fpu_s;
            r_err    <= 1'b0;
         end else if (w_abort) begin
            r_result <= 32'h7FC00000;
            r_err    <= 1'b1;
         end
         if (r_state == RESP) r_ptr <= ~r_win;
      end
   assign bus.busy              = r_state != IDLE;
   assign bus.fpu_start         = (r_state == ISSUE) || (r_state == WAIT);
   assign bus.done0             = (r_state == RESP) && !r_win;
   assign bus.done1             = (r_state == RESP) && r_win;
   assign bus.result            = r_result;
   assign bus.err               = r_err;
   assign bus.fpu_a             = r_a;
   assign bus.fpu_b             = r_b;
   assign bus.fpu_multiplicando = r_mul;
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed and randomized bench for fpu_arbiter against a cycle-age reference model
`timescale 1ns/1ps
module tb_fpu_arbiter;
   localparam int TO = 16;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   fpu_arbiter_if bus();
   fpu_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
   typedef struct { bit id; logic [31:0] res; bit err; int cyc; } done_t;
   done_t served[$];
   int checks = 0, errors = 0, cyc = 0;
   int last_rise = -1, rise_cyc = -1, start_len = 0, slen = 0;
   bit prev_start = 0;
   bit rnd = 0, noise = 0, stale = 0, never = 0, hold0 = 0, hold1 = 0;
   int fix_lat = 4;
   int m_age = -1;
   bit m_resp = 0, m_ptr = 0, m_win = 0, m_op = 0, m_err = 0;
   logic [31:0] m_a = '0, m_b = '0, m_res = '0;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b, input logic m);
      if (m && a == 32'hC0200000 && b == 32'hC0400000) return 32'h40F00000;
      if (!m && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
      return {a[15:0], a[31:16]} ^ b ^ {32{m}};
   endfunction

   // reference: m_age counts cycles since the grant (-1 when nothing is in flight)
   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         m_age = -1; m_resp = 0; m_ptr = 0; m_win = 0; m_op = 0; m_err = 0;
         m_a = '0; m_b = '0; m_res = '0;
      end else if (m_resp) begin
         m_resp = 0;
         m_ptr = !m_win;
      end else if (m_age < 0) begin
         if (bus.req0 || bus.req1) begin
            if (bus.req0 && bus.req1) m_win = m_ptr;
            else m_win = bus.req1;
            m_a = m_win ? bus.a1 : bus.a0;
            m_b = m_win ? bus.b1 : bus.b0;
            m_op = m_win ? bus.op1 : bus.op0;
            m_age = 0;
         end
      end else if (m_age >= 1 && bus.fpu_finish) begin
         m_res = bus.fpu_s; m_err = 0; m_resp = 1; m_age = -1;
      end
`ifdef FPU_ARB_TIMEOUT_EN
      else if (m_age == TO) begin
         m_res = 32'h7FC00000; m_err = 1; m_resp = 1; m_age = -1;
      end
`endif
      else m_age++;
   end

   // compare DUT against the model every cycle, and log completions and start rises
   initial forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
         last_rise = -1;
         prev_start = 0;
      end else begin
         chk("busy", bus.busy, (m_age >= 0) || m_resp);
         chk("fpu_start", bus.fpu_start, m_age >= 0);
         chk("done0", bus.done0, m_resp && !m_win);
         chk("done1", bus.done1, m_resp && m_win);
         chk("fpu_a", bus.fpu_a, m_a);
         chk("fpu_b", bus.fpu_b, m_b);
         chk("fpu_multiplicando", bus.fpu_multiplicando, m_op);
         chk("result", bus.result, m_res);
         chk("err", bus.err, m_err);
         if (bus.done0 || bus.done1) served.push_back('{bus.done1, bus.result, bus.err, cyc});
         if (bus.fpu_start && !prev_start) begin
            if (last_rise >= 0) chk("start_gap_ge4", (cyc - last_rise) >= 4, 1);
            last_rise = cyc;
            rise_cyc = cyc;
            slen = 0;
         end
         if (bus.fpu_start) slen++;
         if (!bus.fpu_start && prev_start) start_len = slen;
         prev_start = bus.fpu_start;
      end
   end

   // FPUnit model: finish lat cycles into WAIT; outside WAIT optional noise/stale finish
   initial begin
      int lat, w;
      bit fprev;
      lat = 0; w = -1; fprev = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            bus.fpu_finish = 0;
            bus.fpu_s = '0;
            fprev = 0;
         end else begin
            if (bus.fpu_start && !fprev) begin
               lat = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 5));
               w = -1;
            end else if (bus.fpu_start) w++;
            fprev = bus.fpu_start;
            if (bus.fpu_start && w >= 0) begin
               bus.fpu_finish = (w == lat) && !never;
               bus.fpu_s = (w == lat) ? fpu_fn(bus.fpu_a, bus.fpu_b, bus.fpu_multiplicando) : $urandom;
            end else begin
               bus.fpu_finish = stale || (noise && $urandom_range(0, 1) == 1);
               bus.fpu_s = $urandom;
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
      if (bus.done0 && !hold0) bus.req0 = 0;
      if (bus.done1 && !hold1) bus.req1 = 0;
      if (rnd) begin
         if (!bus.req0 || bus.busy) begin
            bus.a0 = $urandom; bus.b0 = $urandom; bus.op0 = 1'($urandom_range(0, 1));
         end
         if (!bus.req1 || bus.busy) begin
            bus.a1 = $urandom; bus.b1 = $urandom; bus.op1 = 1'($urandom_range(0, 1));
         end
         if (!bus.req0 && $urandom_range(0, 3) == 0) bus.req0 = 1;
         if (!bus.req1 && $urandom_range(0, 3) == 0) bus.req1 = 1;
      end
   endtask

   task automatic wait_done(input int budget, input string n);
      int s = served.size();
      for (int i = 0; i < budget && served.size() == s; i++) step();
      chk(n, served.size() > s, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int bcnt, ones;
      bus.req0 = 0; bus.req1 = 0; bus.op0 = 0; bus.op1 = 0;
      bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst busy", bus.busy, 0);
      chk("rst fpu_start", bus.fpu_start, 0);
      chk("rst done0", bus.done0, 0);
      chk("rst done1", bus.done1, 0);
      chk("rst result", bus.result, 0);
      chk("rst err", bus.err, 0);
      chk("rst fpu_a", bus.fpu_a, 0);
      chk("rst fpu_b", bus.fpu_b, 0);
      chk("rst fpu_mul", bus.fpu_multiplicando, 0);
      reset = 0;
      // multiply on requester 0, FPU finishes 5 cycles after start
      fix_lat = 4;
      bus.op0 = 1; bus.a0 = 32'hC0200000; bus.b0 = 32'hC0400000; bus.req0 = 1;
      wait_done(50, "mul done");
      if (served.size() > 0) begin
         chk("mul id", served[0].id, 0);
         chk("mul result", served[0].res, 32'h40F00000);
         chk("mul err", served[0].err, 0);
      end
      chk("mul start cycles", start_len, 6);
      chk("mul fpu_multiplicando", bus.fpu_multiplicando, 1);
      repeat (4) step();
      chk("mul single done", served.size(), 1);
      // add on requester 1
      served.delete();
      fix_lat = 1;
      bus.op1 = 0; bus.a1 = 32'h3F800000; bus.b1 = 32'h40000000; bus.req1 = 1;
      wait_done(50, "add done");
      if (served.size() > 0) begin
         chk("add id", served[0].id, 1);
         chk("add result", served[0].res, 32'h40400000);
      end
      chk("add fpu_multiplicando", bus.fpu_multiplicando, 0);
      // contention: both held high, alternate service expected
      served.delete();
      fix_lat = -1;
      hold0 = 1; hold1 = 1; bus.req0 = 1; bus.req1 = 1;
      for (int i = 0; i < 4; i++) wait_done(50, "contention done");
      bus.req0 = 0; bus.req1 = 0; hold0 = 0; hold1 = 0;
      for (int i = 0; i < 4; i++) if (i < served.size()) chk("contention order", served[i].id, i % 2);
      repeat (3) step();
      // stale finish: high through IDLE/ISSUE, then a real pulse on the 4th WAIT cycle
      served.delete();
      stale = 1; fix_lat = 3;
      repeat (2) step();
      bus.op0 = 0; bus.a0 = 32'h00001234; bus.b0 = 32'h00005678; bus.req0 = 1;
      wait_done(50, "stale done");
      if (served.size() > 0) begin
         chk("stale result", served[0].res, {16'h1234, 16'h0000} ^ 32'h00005678);
         chk("stale done timing", served[0].cyc - rise_cyc, 5);
      end
      repeat (5) step();
      stale = 0;
      chk("stale single done", served.size(), 1);
      // reset two cycles after fpu_start rises
      served.delete();
      fix_lat = 10;
      bus.a1 = 32'h11112222; bus.b1 = 32'h33334444; bus.op1 = 1; bus.req1 = 1;
      for (int i = 0; i < 10 && !bus.fpu_start; i++) step();
      chk("rst-wait start seen", bus.fpu_start, 1);
      repeat (2) step();
      reset = 1;
      #1;
      chk("rst-wait fpu_start", bus.fpu_start, 0);
      chk("rst-wait busy", bus.busy, 0);
      chk("rst-wait done", {bus.done0, bus.done1}, 0);
      bus.req1 = 0;
      repeat (2) @(negedge clk);
      reset = 0;
      chk("rst-wait no done", served.size(), 0);
      fix_lat = 2;
      bus.a0 = 32'h0BAD0001; bus.req0 = 1; bus.req1 = 1;
      wait_done(50, "post-reset first");
      wait_done(50, "post-reset second");
      if (served.size() > 1) begin
         chk("post-reset first id", served[0].id, 0);
         chk("post-reset second id", served[1].id, 1);
      end
      // randomized traffic with noise on finish outside WAIT
      served.delete();
      rnd = 1; noise = 1; fix_lat = -1;
      repeat (400) step();
      rnd = 0;
      for (int i = 0; i < 200 && (bus.req0 || bus.req1 || bus.busy); i++) step();
      noise = 0;
      chk("random drained", bus.req0 || bus.req1 || bus.busy, 0);
      chk("random activity", served.size() > 20, 1);
      ones = 0;
      foreach (served[i]) if (served[i].id) ones++;
      chk("random both served", (ones > 0) && (ones < served.size()), 1);
      // FPU never finishes
      repeat (2) step();
      served.delete();
      never = 1;
      bus.a0 = 32'h01020304; bus.b0 = 32'h05060708; bus.op0 = 1; bus.req0 = 1;
`ifdef FPU_ARB_TIMEOUT_EN
      wait_done(60, "timeout done");
      if (served.size() > 0) begin
         chk("timeout err", served[0].err, 1);
         chk("timeout result", served[0].res, 32'h7FC00000);
      end
      chk("timeout start cycles", start_len, 1 + TO);
`else
      step();
      bcnt = 0;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (bus.busy) bcnt++;
      end
      chk("no-timeout busy held", bcnt, 1000);
      chk("no-timeout no done", served.size(), 0);
      reset = 1;
      bus.req0 = 0;
      repeat (2) @(negedge clk);
      reset = 0;
`endif
      never = 0;
      repeat (3) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
